// File: rtl/mips_pkg.sv
// Shared types for the multi-cycle MIPS core: sequencer phases, access sizes
// and the bus-master FSM encoding.
package mips_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  // IDLE: no cycle issued this visit; BUSY: slave is stalling us;
  // DONE: this phase visit already had its one bus cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } bus_state_e;

endpackage

// File: rtl/mem_bus_interface_load_align.sv
// load_align: picks the addressed byte/half out of a little-endian read word
// and zero- or sign-extends it. Word loads pass through unchanged.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] readdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension from the raw read word.
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = readdata_i[7:0];
      2'd1:    byte_sel = readdata_i[15:8];
      2'd2:    byte_sel = readdata_i[23:16];
      default: byte_sel = readdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? readdata_i[31:16] : readdata_i[15:0];
    case (mem_size_e'(size_i))
      SZ_BYTE: result_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: result_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: result_o = readdata_i;
    endcase
  end

endmodule

// File: rtl/mem_bus_interface.sv
// mem_bus_interface: Avalon-MM master for the multi-cycle MIPS core. Issues one
// instruction read per FETCH visit and one load/store per MEM visit, owns IR
// and MDR, and stalls the phase sequencer while a bus cycle is outstanding.
// Optional macro ALIGN_CHECK_EN: misaligned half/word data accesses are
// suppressed and flagged on the sticky addr_err output.
//
// Handshake: a request is presented when req=1; it is accepted on the posedge
// where req=1 and avm_waitrequest=0. Address, strobes, byteenable and
// writedata come straight from the held datapath inputs, so they are stable
// from the first req cycle until acceptance.
module mem_bus_interface
  import mips_pkg::*;
#(
  parameter logic [2:0] PH_FETCH = 3'd0,
  parameter logic [2:0] PH_MEM   = 3'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  phase,
  input  logic [31:0] pc,
  input  logic [31:0] mem_addr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
`ifdef ALIGN_CHECK_EN
  output logic        addr_err,
`endif
  input  logic        avm_waitrequest
);

  bus_state_e  state_q, state_d;
  logic [2:0]  prev_phase_q, prev_phase_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] load_val;
  logic [31:0] byte_addr;
  logic [3:0]  be_lane;
  logic [1:0]  a;
  logic        is_fetch, is_mem, data_access, misaligned;
  logic        need, done, req, accept;

  assign a           = mem_addr[1:0];
  assign is_fetch    = (phase == PH_FETCH);
  assign is_mem      = (phase == PH_MEM);
  assign data_access = is_mem & (mem_rd | mem_wr);

  // Alignment screen for data accesses; fetches are never screened.
  always_comb begin
    misaligned = 1'b0;
`ifdef ALIGN_CHECK_EN
    case (mem_size_e'(mem_size))
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = data_access & a[0];
      default: misaligned = data_access & (a != 2'd0);
    endcase
`endif
  end

  // Request generation; reset masks every strobe during the reset cycle.
  assign need   = is_fetch | (data_access & ~misaligned);
  assign done   = (state_q == ST_DONE);
  assign req    = need & ~done & ~reset;
  assign accept = req & ~avm_waitrequest;
  assign stall  = req & avm_waitrequest;

  assign avm_read  = req & (is_fetch | mem_rd);
  assign avm_write = req & is_mem & mem_wr;

  // Byte-lane steering for data accesses (little-endian lanes).
  always_comb begin
    case (mem_size_e'(mem_size))
      SZ_BYTE: begin
        be_lane       = 4'b0001 << a;
        avm_writedata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        be_lane       = a[1] ? 4'b1100 : 4'b0011;
        avm_writedata = {2{store_data[15:0]}};
      end
      default: begin
        be_lane       = 4'b1111;
        avm_writedata = store_data;
      end
    endcase
  end

  assign byte_addr      = is_fetch ? pc : mem_addr;
  assign avm_address    = byte_addr & 32'hFFFF_FFFC;
  assign avm_byteenable = req ? (is_fetch ? 4'b1111 : be_lane) : 4'b0000;

  load_align u_load_align (
    .readdata_i (avm_readdata),
    .addr_lo_i  (a),
    .size_i     (mem_size),
    .signed_i   (mem_signed),
    .result_o   (load_val)
  );

  // Next-state: one bus cycle per phase visit, captured data on acceptance.
  always_comb begin
    state_d      = state_q;
    prev_phase_d = prev_phase_q;
    ir_d         = ir_q;
    mdr_d        = mdr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept)   state_d = ST_DONE;
        else if (req) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (accept)    state_d = ST_DONE;
        else if (!req) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (phase != prev_phase_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      prev_phase_d = phase;
      if (is_fetch)    ir_d  = avm_readdata;
      else if (mem_rd) mdr_d = load_val;
    end
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prev_phase_q <= 3'd0;
      ir_q         <= 32'd0;
      mdr_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      prev_phase_q <= prev_phase_d;
      ir_q         <= ir_d;
      mdr_q        <= mdr_d;
    end
  end

  assign ir  = ir_q;
  assign mdr = mdr_q;

`ifdef ALIGN_CHECK_EN
  logic addr_err_q;

  // Sticky misalignment flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)           addr_err_q <= 1'b0;
    else if (misaligned) addr_err_q <= 1'b1;
  end

  assign addr_err = addr_err_q;
`endif

endmodule

// File: tb/tb_mem_bus_interface.sv
// Directed bench for mem_bus_interface: fetch with wait states, signed and
// unsigned byte/half loads, lane-steered stores, reset mid-transaction, idle
// phases, and word access at an unaligned address (with or without
// ALIGN_CHECK_EN).
module tb_mem_bus_interface;

  logic        clk;
  logic        reset;
  logic [2:0]  phase;
  logic [31:0] pc;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
`ifdef ALIGN_CHECK_EN
  logic        addr_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int rd_acc   = 0;
  int rd_base;

  mem_bus_interface dut (
    .clk             (clk),
    .reset           (reset),
    .phase           (phase),
    .pc              (pc),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .mem_size        (mem_size),
    .mem_signed      (mem_signed),
    .store_data      (store_data),
    .stall           (stall),
    .ir              (ir),
    .mdr             (mdr),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_byteenable  (avm_byteenable),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
`ifdef ALIGN_CHECK_EN
    .addr_err        (addr_err),
`endif
    .avm_waitrequest (avm_waitrequest)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count accepted reads, sampled mid-cycle before the accepting edge.
  always @(negedge clk) begin
    if (avm_read && !avm_waitrequest) rd_acc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic set_data(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] addr, input logic [31:0] sd);
    mem_rd     = rd;
    mem_wr     = wr;
    mem_size   = sz;
    mem_signed = sg;
    mem_addr   = addr;
    store_data = sd;
  endtask

  initial begin
    reset = 1'b1; phase = 3'd1; pc = 32'd0; avm_readdata = 32'd0;
    avm_waitrequest = 1'b0;
    set_data(1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0);
    step(); step();
    // Reset state, with FETCH presented while reset is held
    phase = 3'd0; settle();
    check("rst_read", {31'd0, avm_read}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_be", {28'd0, avm_byteenable}, 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_mdr", mdr, 32'd0);

    // 1. FETCH with three wait cycles
    reset = 1'b0; pc = 32'h0000_0100; avm_readdata = 32'h2402_0005;
    avm_waitrequest = 1'b1; rd_base = rd_acc;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("f_stall", {31'd0, stall}, 32'd1);
      check("f_addr", avm_address, 32'h0000_0100);
      check("f_be", {28'd0, avm_byteenable}, 32'hF);
      step();
    end
    avm_waitrequest = 1'b0; settle();
    check("f_acc_stall", {31'd0, stall}, 32'd0);
    check("f_acc_read", {31'd0, avm_read}, 32'd1);
    step();
    check("f_ir", ir, 32'h2402_0005);
    check("f_done_read", {31'd0, avm_read}, 32'd0);
    step(); step();
    check("f_one_read", rd_acc - rd_base, 32'd1);
    phase = 3'd1; step();
    phase = 3'd2; step();

    // 2. Byte loads at lane 3, signed then unsigned; then a signed half
    phase = 3'd3; avm_readdata = 32'h80FF_1234;
    set_data(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'd0); settle();
    check("lb_be", {28'd0, avm_byteenable}, 32'h8);
    check("lb_addr", avm_address, 32'h0000_0200);
    check("lb_write", {31'd0, avm_write}, 32'd0);
    step();
    check("lb_mdr_s", mdr, 32'hFFFF_FF80);
    phase = 3'd4; step();
    phase = 3'd3; mem_signed = 1'b0; step();
    check("lbu_mdr", mdr, 32'h0000_0080);
    phase = 3'd4; step();
    phase = 3'd3; set_data(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'd0); settle();
    check("lh_be", {28'd0, avm_byteenable}, 32'hC);
    step();
    check("lh_mdr_s", mdr, 32'hFFFF_80FF);

    // 3. Halfword store at 0x402 with one wait cycle
    phase = 3'd4; step();
    phase = 3'd3; avm_waitrequest = 1'b1;
    set_data(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0402, 32'h0000_BEEF); settle();
    check("sh_write", {31'd0, avm_write}, 32'd1);
    check("sh_read", {31'd0, avm_read}, 32'd0);
    check("sh_stall", {31'd0, stall}, 32'd1);
    check("sh_be", {28'd0, avm_byteenable}, 32'hC);
    check("sh_wdata", avm_writedata, 32'hBEEF_BEEF);
    check("sh_addr", avm_address, 32'h0000_0400);
    step();
    avm_waitrequest = 1'b0; settle();
    check("sh_hold_wdata", avm_writedata, 32'hBEEF_BEEF);
    step();
    check("sh_mdr_keep", mdr, 32'hFFFF_80FF);
    check("sh_done_write", {31'd0, avm_write}, 32'd0);
    // Byte store at lane 1
    phase = 3'd4; step();
    phase = 3'd3; set_data(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0401, 32'h1234_5678); settle();
    check("sb_be", {28'd0, avm_byteenable}, 32'h2);
    check("sb_wdata", avm_writedata, 32'h7878_7878);
    step();

    // 5. MEM without rd/wr, then phase 5 with mem_rd set
    phase = 3'd4; step();
    phase = 3'd3; set_data(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'd0); settle();
    check("nop_read", {31'd0, avm_read}, 32'd0);
    check("nop_write", {31'd0, avm_write}, 32'd0);
    check("nop_stall", {31'd0, stall}, 32'd0);
    step();
    phase = 3'd5; mem_rd = 1'b1; avm_waitrequest = 1'b1; settle();
    check("ph5_read", {31'd0, avm_read}, 32'd0);
    check("ph5_stall", {31'd0, stall}, 32'd0);
    step();
    avm_waitrequest = 1'b0;

    // 6. Word load at 0x101
    phase = 3'd4; step();
    phase = 3'd3; avm_readdata = 32'hCAFE_F00D;
    set_data(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'd0); settle();
`ifdef ALIGN_CHECK_EN
    check("lw_mis_read", {31'd0, avm_read}, 32'd0);
    check("lw_mis_stall", {31'd0, stall}, 32'd0);
    step();
    check("lw_mis_err", {31'd0, addr_err}, 32'd1);
    check("lw_mis_mdr", mdr, 32'hFFFF_80FF);
    phase = 3'd4; step();
    phase = 3'd3; mem_addr = 32'h0000_0104; settle();
    check("lw_ok_read", {31'd0, avm_read}, 32'd1);
    step();
    check("lw_ok_mdr", mdr, 32'hCAFE_F00D);
    check("err_sticky", {31'd0, addr_err}, 32'd1);
`else
    check("lw_un_read", {31'd0, avm_read}, 32'd1);
    check("lw_un_addr", avm_address, 32'h0000_0100);
    check("lw_un_be", {28'd0, avm_byteenable}, 32'hF);
    step();
    check("lw_un_mdr", mdr, 32'hCAFE_F00D);
`endif
    set_data(1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0);

    // 4. Reset while a fetch is stalled
    phase = 3'd4; step();
    phase = 3'd0; pc = 32'h0000_0300; avm_waitrequest = 1'b1;
    avm_readdata = 32'h8C08_0004; step();
    check("rf_stall_pre", {31'd0, stall}, 32'd1);
    reset = 1'b1; step();
    check("rf_read", {31'd0, avm_read}, 32'd0);
    check("rf_stall", {31'd0, stall}, 32'd0);
    check("rf_ir", ir, 32'd0);
`ifdef ALIGN_CHECK_EN
    check("rf_err_clr", {31'd0, addr_err}, 32'd0);
`endif
    reset = 1'b0; rd_base = rd_acc; settle();
    check("rf_reissue", {31'd0, avm_read}, 32'd1);
    check("rf_reissue_stall", {31'd0, stall}, 32'd1);
    step();
    avm_waitrequest = 1'b0; step();
    check("rf_ir_new", ir, 32'h8C08_0004);
    step(); step();
    check("rf_one_read", rd_acc - rd_base, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
